// File: rtl/fft_iterative_engine.sv
// Iterative radix-2 DIT FFT/IFFT over a whole frame held in working registers.
// Latency: LOG2N cycles from the accepting edge to send_val (one stage per cycle).
// Backpressure: holds the result in DONE until send_rdy; no input accepted in COMPUTE.
//
// Ports:
//   clk, reset (async, active-low)
//   recv_msg_real/imag, recv_val, recv_rdy, inverse : input frame, time order
//   send_msg_real/imag, send_val, send_rdy          : output frame, natural frequency order
//   sine_wave_out                                   : sin(2*pi*i/N) table, fixed point
// Build option: define FFT_STAGE_SCALE_EN to halve every butterfly output per
// stage, so the final result is DFT/N_SAMPLES.
module fft_iterative_engine #(
  parameter int BIT_WIDTH  = 32,
  parameter int DECIMAL_PT = 16,
  parameter int N_SAMPLES  = 8
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_real,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] recv_msg_imag,
  input  logic                                recv_val,
  output logic                                recv_rdy,
  input  logic                                inverse,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_real,
  output logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] send_msg_imag,
  output logic                                send_val,
  input  logic                                send_rdy,
  input  logic [N_SAMPLES-1:0][BIT_WIDTH-1:0] sine_wave_out
);

  localparam int LOG2N = $clog2(N_SAMPLES);
  localparam int SW    = (LOG2N > 1) ? $clog2(LOG2N) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COMPUTE = 2'd1;
  localparam logic [1:0] DONE    = 2'd2;

  typedef logic signed [BIT_WIDTH-1:0] word_t;

  logic [1:0]    state;
  logic [SW-1:0] stage_cnt;
  logic          inv_q;
  word_t         work_re [N_SAMPLES];
  word_t         work_im [N_SAMPLES];
  word_t         nxt_re  [N_SAMPLES];
  word_t         nxt_im  [N_SAMPLES];
  logic          accept;

  // Fixed-point multiply: full-width signed product, arithmetic shift, then truncate.
  function automatic word_t fmul(input word_t x, input word_t y);
    logic signed [2*BIT_WIDTH-1:0] xe, ye, p;
    xe = {{BIT_WIDTH{x[BIT_WIDTH-1]}}, x};
    ye = {{BIT_WIDTH{y[BIT_WIDTH-1]}}, y};
    p  = xe * ye;
    p  = p >>> DECIMAL_PT;
    return p[BIT_WIDTH-1:0];
  endfunction

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int b = 0; b < LOG2N; b++) r[b] = v[LOG2N-1-b];
    return r;
  endfunction

  assign accept   = recv_val && recv_rdy;
  assign send_val = (state == DONE);
  // Gated by reset so the input side never looks ready while the block is held.
  assign recv_rdy = reset && ((state == IDLE) || ((state == DONE) && send_rdy));

  // One full DIT stage: every lower index i (bit s clear) owns the butterfly
  // with partner i + 2^s; twiddle index is (i mod 2^s) * N / 2^(s+1).
  always_comb begin
    int               s;
    logic [LOG2N-1:0] ia, ib, tw, tc;
    word_t            wr, wi, tr, ti, sr, si, dr, di;
    s  = int'(stage_cnt);
    ia = '0; ib = '0; tw = '0; tc = '0;
    wr = '0; wi = '0; tr = '0; ti = '0;
    sr = '0; si = '0; dr = '0; di = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      nxt_re[i] = work_re[i];
      nxt_im[i] = work_im[i];
    end
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (((i >> s) & 1) == 0) begin
        ia = LOG2N'(i);
        ib = LOG2N'(i + (1 << s));
        tw = LOG2N'((i & ((1 << s) - 1)) << (LOG2N - 1 - s));
        // cos(x) = sin(x + pi/2); the index wraps mod N through the width.
        tc = tw + LOG2N'(N_SAMPLES / 4);
        wr = sine_wave_out[tc];
        wi = inv_q ? word_t'(sine_wave_out[tw]) : -word_t'(sine_wave_out[tw]);
        tr = fmul(wr, work_re[ib]) - fmul(wi, work_im[ib]);
        ti = fmul(wr, work_im[ib]) + fmul(wi, work_re[ib]);
        sr = work_re[ia] + tr;
        si = work_im[ia] + ti;
        dr = work_re[ia] - tr;
        di = work_im[ia] - ti;
`ifdef FFT_STAGE_SCALE_EN
        nxt_re[ia] = sr >>> 1;
        nxt_im[ia] = si >>> 1;
        nxt_re[ib] = dr >>> 1;
        nxt_im[ib] = di >>> 1;
`else
        nxt_re[ia] = sr;
        nxt_im[ia] = si;
        nxt_re[ib] = dr;
        nxt_im[ib] = di;
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      stage_cnt <= '0;
      inv_q     <= 1'b0;
      for (int i = 0; i < N_SAMPLES; i++) begin
        work_re[i] <= '0;
        work_im[i] <= '0;
      end
    end else if (accept) begin
      // Bit-reversed load so the in-place stages finish in natural order.
      for (int i = 0; i < N_SAMPLES; i++) begin
        work_re[i] <= recv_msg_real[bitrev(LOG2N'(i))];
        work_im[i] <= recv_msg_imag[bitrev(LOG2N'(i))];
      end
      inv_q     <= inverse;
      stage_cnt <= '0;
      state     <= COMPUTE;
    end else begin
      case (state)
        COMPUTE: begin
          for (int i = 0; i < N_SAMPLES; i++) begin
            work_re[i] <= nxt_re[i];
            work_im[i] <= nxt_im[i];
          end
          if (stage_cnt == SW'(LOG2N - 1)) begin
            stage_cnt <= '0;
            state     <= DONE;
          end else begin
            stage_cnt <= stage_cnt + 1'b1;
          end
        end
        DONE:    if (send_rdy) state <= IDLE;
        IDLE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    send_msg_real = '0;
    send_msg_imag = '0;
    for (int i = 0; i < N_SAMPLES; i++) begin
      if (send_val) begin
        send_msg_real[LOG2N'(i)] = work_re[i];
        send_msg_imag[LOG2N'(i)] = work_im[i];
      end
    end
  end

endmodule

// File: doc/fft_iterative_engine.md
FFT_ITERATIVE_ENGINE -- requirements
Module: fft_iterative_engine

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 32: signed fixed-point word width.
REQ-002 SHALL have parameter DECIMAL_PT, default 16: fractional bits.
REQ-003 SHALL have parameter N_SAMPLES, default 8: FFT size; power of two, 4..64; LOG2N = log2(N_SAMPLES).
REQ-004 SHALL have port clk  input  1: sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port recv_msg_real / recv_msg_imag  input  BIT_WIDTH x N_SAMPLES: input samples, time order.
REQ-007 SHALL have port recv_val  input  1 and port recv_rdy  output  1: input handshake.
REQ-008 SHALL have port inverse  input  1: sampled with the input frame; 1 = inverse transform.
REQ-009 SHALL have port send_msg_real / send_msg_imag  output  BIT_WIDTH x N_SAMPLES: results, natural frequency order.
REQ-010 SHALL have port send_val  output  1 and port send_rdy  input  1: output handshake.
REQ-011 SHALL have port sine_wave_out  input  BIT_WIDTH x N_SAMPLES: entry i = sin(2*pi*i/N_SAMPLES), fixed point.

Function
REQ-012 SHALL implement FSM IDLE -> COMPUTE -> DONE, with a stage counter 0..LOG2N-1.
REQ-013 SHALL assert recv_rdy in IDLE, and in DONE when send_rdy=1; recv_rdy SHALL be 0 in COMPUTE.
REQ-014 On recv_val&&recv_rdy, SHALL load the working registers in bit-reversed index order, latch inverse, clear the stage counter and enter COMPUTE.
REQ-015 In COMPUTE, SHALL apply one radix-2 DIT stage per cycle to all N_SAMPLES/2 butterflies and write results back to the working registers.
REQ-016 Stage s SHALL pair indices i and i+2^s for bit s of i = 0.
REQ-017 Stage s twiddle index t SHALL be k*N_SAMPLES/2^(s+1), where k = i mod 2^s.
REQ-018 Twiddle real part SHALL be sine_wave_out[(t+N/4) mod N].
REQ-019 Twiddle imag part SHALL be -sine_wave_out[t], or +sine_wave_out[t] when the latched inverse = 1.
REQ-020 Butterfly SHALL compute a' = a + W*b and b' = a - W*b.
REQ-021 Each product SHALL be a full 2*BIT_WIDTH signed product, arithmetically shifted right by DECIMAL_PT, then truncated to BIT_WIDTH.
REQ-022 Add/subtract SHALL wrap modulo 2^BIT_WIDTH, with no saturation.
REQ-023 After stage LOG2N-1, SHALL enter DONE; send_val SHALL rise exactly LOG2N cycles after the accepting edge.
REQ-024 In DONE, send_val=1 and send_msg_* SHALL be driven from the working registers and held stable until send_rdy=1.
REQ-025 DONE with send_rdy=1 and recv_val=0 SHALL go to IDLE.
REQ-026 DONE with send_rdy=1 and recv_val=1 SHALL load the new frame and go directly to COMPUTE, giving back-to-back frames with no idle cycle.
REQ-027 send_msg_* SHALL be 0 whenever send_val=0.
REQ-028 recv_val SHALL be ignored in COMPUTE, and input data SHALL not be sampled there.

Reset
REQ-029 reset low SHALL immediately force: state IDLE, stage counter 0, working registers 0, latched inverse 0, send_val 0, send_msg_* 0.
REQ-030 recv_rdy SHALL be 0 while reset is low and 1 on the first cycle after release.
REQ-031 Reset asserted mid-COMPUTE or in DONE SHALL discard the frame with no output handshake.

Configuration
REQ-032 With macro FFT_STAGE_SCALE_EN defined, every butterfly output SHALL be arithmetically shifted right by 1 (floor) per stage, so the final output = DFT/N_SAMPLES.
REQ-033 Without FFT_STAGE_SCALE_EN, outputs SHALL be unscaled and wrapping; latency and handshake SHALL be identical in both builds.

Verification (N_SAMPLES=8, BIT_WIDTH=32, DECIMAL_PT=16, exact sine table)
REQ-034 Impulse: x[0]=0x00010000, all others 0, inverse=0.
- Required: all real outputs = 0x00010000 (0x00002000 with FFT_STAGE_SCALE_EN), all imag = 0.
- Required: send_val high 3 cycles after accept.
REQ-035 DC: all real inputs = 0x00010000.
- Required: X[0] real = 0x00080000 (0x00010000 scaled), all other outputs 0.
- Required: the same result with inverse=1.
REQ-036 Backpressure: hold send_rdy=0 for 5 cycles in DONE.
- Required: outputs stable, send_val=1, recv_rdy=0.
- Required: on send_rdy=1 with recv_val=0, IDLE next cycle.
REQ-037 Back-to-back: present frame B with recv_val held high while frame A is in DONE and send_rdy=1.
- Required: B is accepted on the same edge A is sent; B's send_val follows 3 cycles later.
REQ-038 Reset mid-compute: drop reset for 1 cycle at stage 1.
- Required: send_val never rises, all outputs 0, recv_rdy=1 after release.
REQ-039 Inverse round trip: run the forward FFT of a random 8-point frame (|x| < 0.25), then feed the result back with inverse=1 (unscaled build).
- Required: output = 8*x within +/-16 LSB.
